// File: rtl/widget_fifo_rtl.sv
// Elastic WIDTH x DEPTH word buffer with valid/ready on both sides.
// Each accepted word is transformed by mode at push time and stored already transformed.
module widget_fifo_rtl #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   input  logic [1:0]       mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic [CW-1:0]    level
);

   localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] LV_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] LV_ZERO = {CW{1'b0}};

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_level;
   logic [WIDTH-1:0] r_prev;

   logic             w_in_ready;
   logic             w_out_valid;
   logic             w_push;
   logic             w_pop;
   logic [WIDTH-1:0] w_word;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = d[WIDTH-1-i];
      end
      return r;
   endfunction

   // Handshakes depend only on the registered level, so out_ready never reaches in_ready.
   assign w_in_ready  = (r_level != LV_FULL);
   assign w_out_valid = (r_level != LV_ZERO);
   assign w_push      = in_valid && w_in_ready;
   assign w_pop       = w_out_valid && out_ready;

   // Per-word transform selected by mode at the moment of acceptance.
   always_comb begin
      w_word = data_in;
      case (mode)
         2'b00:   w_word = data_in;
         2'b01:   w_word = ~data_in;
         2'b10:   w_word = bit_rev(data_in);
         2'b11:   w_word = data_in ^ r_prev;
         default: w_word = data_in;
      endcase
   end

   // Storage array is deliberately not reset; level gating keeps stale entries off data_out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_word;
      end
   end

   // Pointers wrap naturally modulo DEPTH; prev always tracks the raw pushed value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_prev   <= {WIDTH{1'b0}};
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1'b1);
            r_prev   <= data_in;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1'b1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= LV_ZERO;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + CW'(1'b1);
            2'b01:   r_level <= r_level - CW'(1'b1);
            default: r_level <= r_level;
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign level     = r_level;
   assign data_out  = w_out_valid ? r_mem[r_rd_ptr] : {WIDTH{1'b0}};

endmodule

// File: tb/tb_widget_fifo_rtl.sv
// Bench for widget_fifo_rtl: constant vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_widget_fifo_rtl;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data_in;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic [CW-1:0]    level;

   int checks   = 0;
   int failures = 0;

   logic [7:0] mq[$];
   logic [7:0] mprev;

   typedef struct {
      logic       iv;
      logic       orr;
      logic [7:0] d;
      logic [1:0] m;
      logic       ev;
      logic [7:0] ed;
      logic [2:0] el;
      logic       eir;
   } vec_t;

   vec_t vt[9];

   widget_fifo_rtl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in), .mode(mode),
      .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
      .level(level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] xf(input logic [7:0] d, input logic [1:0] m, input logic [7:0] p);
      logic [7:0] r;
      case (m)
         2'b00:   r = d;
         2'b01:   r = ~d;
         2'b10:   r = {<<{d}};
         default: r = d ^ p;
      endcase
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic compare_model();
      chk("level", {29'd0, level}, mq.size());
      chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
      chk("in_ready", {31'd0, in_ready}, {31'd0, mq.size() != DEPTH});
      chk("data_out", {24'd0, data_out}, (mq.size() != 0) ? {24'd0, mq[0]} : 32'd0);
   endtask

   task automatic model_reset();
      mq.delete();
      mprev = 8'h00;
   endtask

   // Drive one cycle of inputs, advance the model at the edge, compare #1 after it.
   task automatic step(input logic iv, input logic orr, input logic [7:0] d, input logic [1:0] m);
      bit push;
      bit pop;
      logic [7:0] tmp;
      in_valid  = iv;
      out_ready = orr;
      data_in   = d;
      mode      = m;
      push = iv && (mq.size() != DEPTH);
      pop  = orr && (mq.size() != 0);
      @(posedge clk);
      #1;
      if (pop) tmp = mq.pop_front();
      if (push) begin
         mq.push_back(xf(d, m, mprev));
         mprev = d;
      end
      compare_model();
   endtask

   initial begin
      logic acc5;
      logic iv5;

      vt[0] = '{1'b1, 1'b0, 8'hA5, 2'b00, 1'b1, 8'hA5, 3'd1, 1'b1};
      vt[1] = '{1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b1};
      vt[2] = '{1'b1, 1'b0, 8'h01, 2'b01, 1'b1, 8'hFE, 3'd1, 1'b1};
      vt[3] = '{1'b1, 1'b0, 8'h01, 2'b10, 1'b1, 8'hFE, 3'd2, 1'b1};
      vt[4] = '{1'b1, 1'b0, 8'h0F, 2'b11, 1'b1, 8'hFE, 3'd3, 1'b1};
      vt[5] = '{1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 8'h80, 3'd2, 1'b1};
      vt[6] = '{1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 8'h0E, 3'd1, 1'b1};
      vt[7] = '{1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b1};
      vt[8] = '{1'b0, 1'b1, 8'h00, 2'b00, 1'b0, 8'h00, 3'd0, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = 8'h00;
      mode      = 2'b00;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_level", {29'd0, level}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_data_out", {24'd0, data_out}, 32'd0);
      rst_n = 1'b1;

      // Constant vector table: single push/pop and the four transforms.
      for (int i = 0; i < 9; i++) begin
         step(vt[i].iv, vt[i].orr, vt[i].d, vt[i].m);
         chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vt[i].ev});
         chk($sformatf("vec%0d_data", i), {24'd0, data_out}, {24'd0, vt[i].ed});
         chk($sformatf("vec%0d_level", i), {29'd0, level}, {29'd0, vt[i].el});
         chk($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vt[i].eir});
      end

      // Fill with back-pressure, hold a fifth word, then drain with no gaps.
      for (int k = 1; k <= 4; k++) step(1'b1, 1'b0, 8'(k), 2'b00);
      chk("fill_level", {29'd0, level}, 32'd4);
      chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
      step(1'b1, 1'b0, 8'h05, 2'b00);
      step(1'b1, 1'b0, 8'h05, 2'b00);
      chk("full_hold_level", {29'd0, level}, 32'd4);
      acc5 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk($sformatf("drain_word%0d", k), {24'd0, data_out}, k);
         chk($sformatf("drain_valid%0d", k), {31'd0, out_valid}, 32'd1);
         iv5 = !acc5;
         if (iv5 && in_ready) acc5 = 1'b1;
         step(iv5, 1'b1, 8'h05, 2'b00);
         if (k == 1) begin
            chk("full_pop_only_level", {29'd0, level}, 32'd3);
            chk("full_pop_in_ready", {31'd0, in_ready}, 32'd1);
         end
      end
      chk("drain_level", {29'd0, level}, 32'd0);

      // Simultaneous push and pop at level 2; pointers wrap several times.
      step(1'b1, 1'b0, 8'h10, 2'b00);
      step(1'b1, 1'b0, 8'h11, 2'b00);
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 1'b1, 8'(8'h12 + i), 2'b00);
         chk($sformatf("pp_level%0d", i), {29'd0, level}, 32'd2);
         chk($sformatf("pp_head%0d", i), {24'd0, data_out}, 32'h11 + i);
      end
      step(1'b0, 1'b1, 8'h00, 2'b00);
      step(1'b0, 1'b1, 8'h00, 2'b00);

      // Asynchronous reset between edges at level 3, then XOR mode after release.
      step(1'b1, 1'b0, 8'h21, 2'b00);
      step(1'b1, 1'b0, 8'h22, 2'b01);
      step(1'b1, 1'b0, 8'h23, 2'b00);
      chk("pre_reset_level", {29'd0, level}, 32'd3);
      in_valid = 1'b0;
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_out_valid", {31'd0, out_valid}, 32'd0);
      chk("async_level", {29'd0, level}, 32'd0);
      chk("async_in_ready", {31'd0, in_ready}, 32'd1);
      chk("async_data_out", {24'd0, data_out}, 32'd0);
      @(posedge clk);
      #1;
      chk("in_reset_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 8'h3C, 2'b11);
      chk("post_reset_xor", {24'd0, data_out}, 32'h3C);
      chk("post_reset_level", {29'd0, level}, 32'd1);
      step(1'b0, 1'b1, 8'h00, 2'b00);

      // Randomized traffic: producer-heavy, balanced, then consumer-heavy phases.
      for (int i = 0; i < 600; i++) begin
         logic iv;
         logic orr;
         if (i < 200) begin
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 3) == 0);
         end else if (i < 400) begin
            iv  = $urandom_range(0, 1) == 1;
            orr = $urandom_range(0, 1) == 1;
         end else begin
            iv  = ($urandom_range(0, 3) == 0);
            orr = ($urandom_range(0, 3) != 0);
         end
         step(iv, orr, 8'($urandom), 2'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/widget_fifo_rtl.md
Name: widget_fifo_rtl

Overview:
- Parametrised successor to the single-bit widget data path.
- Carries WIDTH-bit words through a DEPTH-entry elastic buffer with valid/ready handshakes on both sides.
- Applies a per-word transform (pass, invert, bit-reverse, running-XOR) chosen by a mode input when each word is accepted.
- Sits between a producer and a consumer that may stall independently.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, buffer entries (power of 2, >=2).
- CW, $clog2(DEPTH+1), width of the level output (derived; not overridden).

Ports:
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has a word on data_in.
- in_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  producer word.
- mode  input  2  transform for the word accepted this cycle.
- out_valid  output  1  data_out holds a valid word.
- out_ready  input  1  consumer takes the word this cycle.
- data_out  output  WIDTH  head-of-buffer word, already transformed.
- level  output  CW  number of occupied entries.

Behaviour:
- Transfer rules:
  - Push when in_valid && in_ready.
  - Pop when out_valid && out_ready.
  - Each is evaluated on the rising clk edge.
- Handshake outputs:
  - in_ready = (level != DEPTH). No combinational path from out_ready; a full buffer does not accept even if a pop happens that cycle.
  - out_valid = (level != 0).
  - data_out = transformed head entry when out_valid, else all zeros.
  - data_out and out_valid hold stable while out_valid && !out_ready.
- Latency:
  - A word pushed at edge N is visible on data_out and out_valid after edge N (1 cycle).
  - No bypass path into an empty buffer.
- Transform, applied at push and stored transformed; mode is sampled only on push:
  - 00: word = data_in.
  - 01: word = ~data_in.
  - 10: word = data_in bit-reversed (bit i -> bit WIDTH-1-i).
  - 11: word = data_in ^ prev, where prev is the raw data_in of the previous push in any mode.
  - prev updates on every push to the raw data_in. prev resets to 0.
- Storage:
  - Write pointer and read pointer, each log2(DEPTH) bits, wrap modulo DEPTH with no special case.
  - level is a registered counter:
    - +1 on push only.
    - -1 on pop only.
    - unchanged on simultaneous push+pop, which is legal whenever 0 < level < DEPTH.
- Boundaries:
  - Empty: pop is impossible (out_valid=0); out_ready is ignored.
  - Full: in_valid is ignored; the word stays with the producer.
  - level never exceeds DEPTH and never underflows.
- Reset (rst_n low, at any time including mid-transfer):
  - Immediately forces pointers, level and prev to 0.
  - Outputs: out_valid=0, data_out=0, level=0.
  - in_ready=1 while in reset and after release.
  - Buffer contents are not reset; all contents are discarded.
  - First push possible on the first rising edge with rst_n high.
- No X on any output after reset, regardless of uninitialised storage.

Test Plan:
- Reset then single push, WIDTH=8: data_in=8'hA5, mode=00 -> out_valid=1 next cycle, data_out=A5, level=1; pop -> level=0, data_out=00.
- Modes, pushed in order 8'h01/01, 8'h01/10, 8'h0F/11 -> pops yield FE, 80, 0E (0F^01). prev tracks the raw value through the non-XOR modes.
- Fill and back-pressure, DEPTH=4: out_ready=0, push 1,2,3,4 -> level=4, in_ready=0; 5th word with in_valid=1 is held, not lost. Then out_ready=1 -> data_out sequence 1,2,3,4,5 with no gaps.
- Simultaneous push+pop at level=2 for 10 cycles -> level stays 2; pointers wrap past DEPTH; order preserved (FIFO).
- Full with out_ready=1 and in_valid=1 in the same cycle -> pop only, level 4->3; the next cycle accepts.
- Async reset asserted mid-stream at level=3, between clock edges -> out_valid=0, level=0, in_ready=1 immediately. After release, push 8'h3C mode=11 -> data_out=3C (prev cleared).
